// File: rtl/uart_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_sender
// Description : Captures an N-byte word and sends it as a framed 8N1 UART
//               packet (header, payload MSB byte first, optional checksum).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_sender #(
    parameter int          CLKS_PER_BIT = 1085,
    parameter int          PERIOD_CLKS  = 125000000,
    parameter int          DATA_BYTES   = 2,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int          CHECKSUM_EN  = 1,
    parameter int          MODE         = 0
) (
    input  logic                    Clk,
    input  logic                    rst_n,
    input  logic [8*DATA_BYTES-1:0] i_data,
    input  logic                    i_trigger,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_drop
);

    localparam int c_NUM_BYTES = 1 + DATA_BYTES + CHECKSUM_EN;
    localparam int c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PER_W     = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam int c_BYTE_W    = $clog2(c_NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_CNT_W-1:0]      r_clk_cnt;
    logic [2:0]              r_bit;
    logic [c_BYTE_W-1:0]     r_byte;
    logic [c_PER_W-1:0]      r_period;
    logic                    r_pend;
    logic                    r_drop;
    logic [8*DATA_BYTES-1:0] r_shadow;
    logic [7:0]              r_csum;

    logic       w_bit_end;
    logic       w_last_byte;
    logic       w_period_wrap;
    logic       w_tick;
    logic       w_evt;
    logic       w_change;
    logic       w_busy;
    logic       w_can_launch;
    logic       w_launch;
    logic [7:0] w_sum;
    logic [7:0] w_cur_byte;

    assign w_bit_end     = (r_clk_cnt == c_CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_byte   = (r_byte == c_BYTE_W'(c_NUM_BYTES - 1));
    assign w_period_wrap = (r_period == c_PER_W'(PERIOD_CLKS - 1));
    assign w_tick        = (MODE == 0) && w_period_wrap;
    assign w_evt         = i_trigger || w_tick;
    // Mode 1 compares against the last frame's snapshot, so a change made
    // mid-frame is picked up in the DONE cycle without using the pending flag.
    assign w_change      = (MODE == 1) && (i_data != r_shadow);
    assign w_busy        = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    assign w_can_launch  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_launch      = w_can_launch && (r_pend || w_evt || w_change);

    assign o_busy        = w_busy;
    assign o_frame_done  = (r_state == S_DONE);
    assign o_drop        = r_drop;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_sum = w_sum + i_data[8*i +: 8];
        end
    end

    always_comb begin
        w_cur_byte = HEADER;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_byte == c_BYTE_W'(i + 1)) begin
                w_cur_byte = r_shadow[8*(DATA_BYTES-1-i) +: 8];
            end
        end
        if ((CHECKSUM_EN != 0) && (r_byte == c_BYTE_W'(DATA_BYTES + 1))) begin
            w_cur_byte = r_csum;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_tx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                o_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                o_tx = w_cur_byte[r_bit];
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = w_last_byte ? S_DONE : S_START;
                end
            end
            S_DONE: begin
                w_state_next = w_launch ? S_START : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_period  <= '0;
            r_pend    <= 1'b0;
            r_drop    <= 1'b0;
            r_shadow  <= '0;
            r_csum    <= '0;
        end else begin
            r_period <= w_period_wrap ? '0 : r_period + 1'b1;
            r_drop   <= w_busy && w_evt && r_pend;

            if (w_launch) begin
                r_shadow <= i_data;
                r_csum   <= w_sum;
            end

            // A relaunch from DONE consumes the pending request; a fresh
            // request arriving in that same cycle stays queued.
            if (w_busy) begin
                if (w_evt) begin
                    r_pend <= 1'b1;
                end
            end else begin
                r_pend <= r_pend && w_evt;
            end

            if (w_busy && !w_bit_end) begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end else begin
                r_clk_cnt <= '0;
            end

            if (r_state == S_START) begin
                r_bit <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit <= r_bit + 1'b1;
            end

            if (!w_busy) begin
                r_byte <= '0;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_byte <= w_last_byte ? '0 : r_byte + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sender.sv
`default_nettype none
// Bench for uart_frame_sender: four instances (periodic, no-checksum,
// change-triggered, trigger-only) checked against a frame-level model.
module tb_uart_frame_sender;

    localparam int CPB = 4;
    localparam int NI  = 4;

    logic            Clk = 1'b0;
    logic [NI-1:0]   rstn;
    logic [NI-1:0]   trig;
    logic [15:0]     din [NI];
    logic [NI-1:0]   tx;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   fdone;
    logic [NI-1:0]   drop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 Clk = ~Clk;

    uart_frame_sender #(.CLKS_PER_BIT(CPB), .PERIOD_CLKS(200), .DATA_BYTES(2),
        .HEADER(8'hA5), .CHECKSUM_EN(1), .MODE(0)) u0 (
        .Clk(Clk), .rst_n(rstn[0]), .i_data(din[0]), .i_trigger(trig[0]),
        .o_tx(tx[0]), .o_busy(busy[0]), .o_frame_done(fdone[0]), .o_drop(drop[0]));
    uart_frame_sender #(.CLKS_PER_BIT(CPB), .PERIOD_CLKS(200), .DATA_BYTES(2),
        .HEADER(8'hA5), .CHECKSUM_EN(0), .MODE(0)) u1 (
        .Clk(Clk), .rst_n(rstn[1]), .i_data(din[1]), .i_trigger(trig[1]),
        .o_tx(tx[1]), .o_busy(busy[1]), .o_frame_done(fdone[1]), .o_drop(drop[1]));
    uart_frame_sender #(.CLKS_PER_BIT(CPB), .PERIOD_CLKS(200), .DATA_BYTES(2),
        .HEADER(8'hA5), .CHECKSUM_EN(1), .MODE(1)) u2 (
        .Clk(Clk), .rst_n(rstn[2]), .i_data(din[2]), .i_trigger(trig[2]),
        .o_tx(tx[2]), .o_busy(busy[2]), .o_frame_done(fdone[2]), .o_drop(drop[2]));
    uart_frame_sender #(.CLKS_PER_BIT(CPB), .PERIOD_CLKS(60000), .DATA_BYTES(2),
        .HEADER(8'hA5), .CHECKSUM_EN(1), .MODE(0)) u3 (
        .Clk(Clk), .rst_n(rstn[3]), .i_data(din[3]), .i_trigger(trig[3]),
        .o_tx(tx[3]), .o_busy(busy[3]), .o_frame_done(fdone[3]), .o_drop(drop[3]));

    // ---------------- model configuration ----------------
    function automatic int per_of(int i);
        return (i == 3) ? 60000 : 200;
    endfunction
    function automatic bit cse_of(int i);
        return (i != 1);
    endfunction
    function automatic bit mode1_of(int i);
        return (i == 2);
    endfunction

    // Whole frame as a flat bit stream (bit 0 sent first).
    function automatic logic [39:0] build(logic [15:0] d, bit cs);
        logic [7:0]  b [4];
        logic [39:0] v;
        b[0] = 8'hA5;
        b[1] = d[15:8];
        b[2] = d[7:0];
        b[3] = d[15:8] + d[7:0];
        v = '1;
        for (int j = 0; j < (cs ? 4 : 3); j++) begin
            v[j*10] = 1'b0;
            for (int n = 0; n < 8; n++) v[j*10+1+n] = b[j][n];
            v[j*10+9] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- model state ----------------
    int          m_t    [NI];   // cycle offset into frame, -1 when not sending
    bit          m_done [NI];
    bit          m_drop [NI];
    bit          m_pend [NI];
    int          m_cnt  [NI];
    logic [15:0] m_last [NI];
    logic [39:0] m_bits [NI];

    always @(posedge Clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rstn[i]) begin
                m_t[i] = -1; m_done[i] = 0; m_drop[i] = 0; m_pend[i] = 0;
                m_cnt[i] = 0; m_last[i] = '0;
            end else begin
                bit tick, evt, chg, launch;
                int flen;
                tick = !mode1_of(i) && (m_cnt[i] == per_of(i) - 1);
                m_cnt[i] = (m_cnt[i] + 1) % per_of(i);
                evt  = trig[i] || tick;
                chg  = mode1_of(i) && (din[i] != m_last[i]);
                flen = (cse_of(i) ? 4 : 3) * 10 * CPB;
                m_drop[i] = 0;
                if (m_t[i] < 0) begin
                    launch    = m_pend[i] || evt || chg;
                    m_pend[i] = m_pend[i] && evt;
                    m_done[i] = 0;
                    if (launch) begin
                        m_last[i] = din[i];
                        m_bits[i] = build(din[i], cse_of(i));
                        m_t[i]    = 0;
                    end
                end else begin
                    if (evt) begin
                        if (m_pend[i]) m_drop[i] = 1;
                        else           m_pend[i] = 1;
                    end
                    m_t[i]++;
                    if (m_t[i] == flen) begin
                        m_t[i]    = -1;
                        m_done[i] = 1;
                    end
                end
            end
        end
    end

    task automatic cmp(string nm, int i, logic a, logic e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s u%0d cycle %0d: got %b, expected %b", nm, i, cyc, a, e);
        end
    endtask

    task automatic chk(string nm, int a, int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, a, a, e, e);
        end
    endtask

    // ---------------- observation: compare + serial decode ----------------
    bit          dact  [NI];
    int          dph   [NI];
    logic [7:0]  dsh   [NI];
    int          brun  [NI];
    logic        pbusy [NI];
    int          ndone [NI];
    int          ndrop [NI];
    logic [7:0]  rxq   [NI][$];
    int          runq  [NI][$];
    int          riseq [NI][$];
    int          doneq [NI][$];

    always @(negedge Clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            logic e_tx, e_busy;
            int k;
            if (!rstn[i]) begin
                cmp("tx", i, tx[i], 1'b1);
                cmp("busy", i, busy[i], 1'b0);
                cmp("frame_done", i, fdone[i], 1'b0);
                cmp("drop", i, drop[i], 1'b0);
                dact[i] = 0; brun[i] = 0; pbusy[i] = 0;
            end else begin
                e_busy = (m_t[i] >= 0);
                e_tx   = e_busy ? m_bits[i][m_t[i] / CPB] : 1'b1;
                cmp("tx", i, tx[i], e_tx);
                cmp("busy", i, busy[i], e_busy);
                cmp("frame_done", i, fdone[i], m_done[i]);
                cmp("drop", i, drop[i], m_drop[i]);

                if (dact[i]) begin
                    dph[i]++;
                    if (dph[i] % CPB == CPB / 2) begin
                        k = dph[i] / CPB;
                        if (k >= 1 && k <= 8) begin
                            dsh[i][k-1] = tx[i];
                        end else if (k == 9) begin
                            cmp("stop_bit", i, tx[i], 1'b1);
                            rxq[i].push_back(dsh[i]);
                            dact[i] = 0;
                        end
                    end
                end else if (tx[i] == 1'b0) begin
                    dact[i] = 1;
                    dph[i]  = 0;
                end

                if (busy[i]) begin
                    if (!pbusy[i]) riseq[i].push_back(cyc);
                    brun[i]++;
                end else if (brun[i] > 0) begin
                    runq[i].push_back(brun[i]);
                    brun[i] = 0;
                end
                pbusy[i] = busy[i];
                if (fdone[i]) begin
                    ndone[i]++;
                    doneq[i].push_back(cyc);
                end
                if (drop[i]) ndrop[i]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_trig(int i);
        @(posedge Clk); #1 trig[i] = 1'b1;
        @(posedge Clk); #1 trig[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int n, int bound);
        int k = 0;
        while (ndone[i] < n && k < bound) begin
            @(posedge Clk);
            k++;
        end
        #1;
        chk($sformatf("wait_done_u%0d", i), (ndone[i] >= n) ? 1 : 0, 1);
    endtask

    task automatic clr(int i);
        rxq[i].delete(); runq[i].delete(); riseq[i].delete(); doneq[i].delete();
        ndone[i] = 0; ndrop[i] = 0;
    endtask

    task automatic chk_frame(int i, int n, logic [63:0] exp, string nm);
        chk({nm, "_count"}, rxq[i].size(), n);
        for (int j = 0; j < n; j++) begin
            if (j < rxq[i].size())
                chk($sformatf("%s_byte%0d", nm, j), rxq[i][j], exp[8*(n-1-j) +: 8]);
        end
    endtask

    function automatic int run_at(int i, int j);
        return (j < runq[i].size()) ? runq[i][j] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rstn = '0; trig = '0;
        din[0] = 16'h1234; din[1] = 16'hFF02; din[2] = 16'h0000; din[3] = 16'h0000;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_tx", tx[0], 1);
        chk("reset_busy", busy[0], 0);
        chk("reset_frame_done", fdone[0], 0);
        chk("reset_drop", drop[0], 0);
        @(posedge Clk); #1 rstn = '1;

        // Periodic frames: checksum, no-checksum.
        wait_done(0, 1, 600);
        wait_done(1, 1, 600);
        step(3);
        chk_frame(0, 4, 64'hA5123446, "t1_frame");
        chk("t1_busy_len", run_at(0, 0), 160);
        chk("t1_done_pulses", ndone[0], 1);
        chk_frame(1, 3, 64'hA5FF02, "t2_nocs_frame");
        chk("t2_nocs_busy_len", run_at(1, 0), 120);

        din[0] = 16'hFF02;
        clr(0);
        wait_done(0, 1, 400);
        step(3);
        chk_frame(0, 4, 64'hA5FF0201, "t2_wrap_frame");

        // Change-triggered mode.
        chk("t4_idle_no_frames", ndone[2], 0);
        din[2] = 16'h00AA;
        step(30);
        din[2] = 16'h00AB;
        wait_done(2, 2, 600);
        step(400);
        chk("t4_done_pulses", ndone[2], 2);
        chk_frame(2, 8, 64'hA500AAAA_A500ABAB, "t4_frames");

        // Pending request and drop.
        clr(3);
        din[3] = 16'h5A01;
        pulse_trig(3);
        din[3] = 16'h7788;
        step(40);
        pulse_trig(3);
        step(20);
        pulse_trig(3);
        wait_done(3, 2, 600);
        step(5);
        chk("t3_done_pulses", ndone[3], 2);
        chk("t3_drop_pulses", ndrop[3], 1);
        chk_frame(3, 8, 64'hA55A015B_A57788FF, "t3_frames");
        chk("t3_gap", (riseq[3].size() > 1 && doneq[3].size() > 0) ? riseq[3][1] - doneq[3][0] : -1, 1);
        chk("t3_busy_len_b", run_at(3, 1), 160);

        // Data churning during a frame.
        clr(3);
        din[3] = 16'hC3E1;
        pulse_trig(3);
        for (int n = 0; n < 170; n++) begin
            din[3] = 16'($urandom);
            step(1);
        end
        din[3] = 16'h0000;
        wait_done(3, 1, 100);
        step(3);
        chk_frame(3, 4, 64'hA5C3E1A4, "t6_frame");
        chk("t6_done_pulses", ndone[3], 1);

        // Reset mid-frame at bit 15 (payload byte 0x00 -> line low there).
        clr(3);
        din[3] = 16'h0034;
        pulse_trig(3);
        repeat (61) @(posedge Clk);
        #1 chk("t5_pre_abort_tx", tx[3], 0);
        rstn[3] = 1'b0;
        #1 chk("t5_abort_tx", tx[3], 1);
        chk("t5_abort_busy", busy[3], 0);
        step(3);
        rstn[3] = 1'b1;
        step(2);
        chk("t5_no_done", ndone[3], 0);
        clr(3);
        din[3] = 16'h1234;
        pulse_trig(3);
        wait_done(3, 1, 300);
        step(3);
        chk_frame(3, 4, 64'hA5123446, "t5_after_reset");
        chk("t5_busy_len", run_at(3, 0), 160);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
